pair_triple_arbiter: RTL and testbench
======================================

# pair_triple_arbiter

Shares one combinational pair/triple (2-of-3 majority) detector among four requesters. Each requester offers a 3-bit operand under a val/rdy handshake; a round-robin arbiter picks one per cycle, the detector evaluates it, and the 1-bit result is registered into a one-entry response buffer tagged with the requester id. It sits between the per-channel operand sources and a single downstream result consumer. It also keeps a wrapping count of results equal to 1.

## Interface
- NREQ, 4, number of requesters (fixed at 4; id width 2)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_val  in  4  per-requester valid; bit i for requester i
- req_rdy  out  4  per-requester ready; at most one bit set (one-hot grant)
- req_bits  in  12  operands; requester i at [3i+2:3i]
- resp_val  out  1  response buffer holds a valid result
- resp_rdy  in  1  consumer accepts the response
- resp_out  out  1  detector result (1 when at least two of the three operand bits are 1)
- resp_id  out  2  id of the requester that produced resp_out
- ones_count  out  8  count of accepted transactions whose result was 1

## Operation
- Buffer FSM, two states: EMPTY (resp_val=0) and FULL (resp_val=1).
- Can-accept = EMPTY, or FULL with resp_rdy=1 (dequeue and enqueue in the same cycle).
- Arbitration: round-robin over req_val, starting the search at (last_grant+1) mod 4. The winner's req_rdy bit is high only when can-accept is true. req_rdy is combinational from req_val, state and resp_rdy.
- Handshake fires for requester i when req_val[i] and req_rdy[i] are both high. On the edge:
  - the buffer loads the detector result for req_bits[3i+2:3i];
  - resp_id <= i;
  - last_grant <= i;
  - state <= FULL;
  - ones_count increments if the result is 1.
- last_grant changes only on a fire. With no requests, the pointer holds.
- In FULL, resp_rdy=1 with no fire: state <= EMPTY. resp_out and resp_id may hold their stale values.
- In FULL, resp_rdy=0: resp_val, resp_out and resp_id are held stable, and req_rdy=0000.
- Losing requesters keep req_val asserted. The block drops nothing.
- ones_count is 8-bit and wraps 255 -> 0. It is not saturating.
- Reset values (immediate, asynchronous):
  - state EMPTY: resp_val=0, resp_out=0, resp_id=0;
  - last_grant=3, so requester 0 has top priority;
  - ones_count=0.
- While rst_n=0, req_rdy=0000. Reset mid-transaction discards the buffered result with no response.

## Timing
- Latency: operand accepted at edge N -> resp_val=1 with the result during cycle N+1.
- Throughput: one transaction per cycle when resp_rdy stays high.
- No combinational path from req_bits to any output. resp_* come directly from flops.
- The combinational path resp_rdy -> req_rdy is allowed and required for full throughput.
- rst_n deassertion is synchronous to clk at the system level. The first grant can occur on the first edge after deassertion.

## Structure
- Shared header PairTripleDefs.v holds:
  - `define for NREQ (4), id width (2), operand width (3), count width (8);
  - state encodings EMPTY=0, FULL=1.
- Sub-module rr_arbiter4: 4-bit req, 2-bit last_grant, enable in; one-hot grant and 2-bit grant id out; purely combinational.
- The 2-of-3 detection function is instantiated once inside the top level on the muxed operand.
- All flops (state, resp_out, resp_id, last_grant, ones_count) live in the top level.

## Test plan
- Reset then single request:
  - stimulus: rst_n pulse, then req_val=0001, req_bits[2:0]=011, resp_rdy=1;
  - required: req_rdy=0001 that cycle; next cycle resp_val=1, resp_out=1, resp_id=0, ones_count=1.
- Fairness:
  - stimulus: req_val=1111 held, resp_rdy=1 from reset;
  - required: grants 0,1,2,3,0 on consecutive cycles, and resp_id follows one cycle later.
- Backpressure:
  - stimulus: buffer FULL with id 2, resp_rdy=0 for 3 cycles, then resp_rdy=1 with req_val=1000;
  - required: req_rdy=0000 and resp_* stable for 3 cycles; then dequeue and enqueue on the same edge, next resp_id=3, resp_val stays 1.
- Detector truth table:
  - stimulus: operands 000,001,010,100 -> resp_out=0; 011,101,110,111 -> resp_out=1;
  - required: ones_count advances by exactly 4.
- Reset mid-operation:
  - stimulus: assert rst_n=0 while resp_val=1 and mid-cycle;
  - required: resp_val, resp_out and resp_id go to 0 and ones_count to 0 before the next edge; after release, req_val=1111 grants requester 0 first.
- Counter wrap:
  - stimulus: 256 accepted operands of 111;
  - required: ones_count reads 255 after the 255th and 0 after the 256th.

Source files
------------

// File: rtl/pair_triple_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pair_triple_arbiter_pkg
// Purpose  : Shared sizes, response-buffer state encoding and the 2-of-3
//            majority function used by the pair/triple arbiter.
// Contents : NREQ, ID_W, OP_W, CNT_W, buf_state_t, maj3()
// Revision : 1.0 - initial release
// ============================================================================
package pair_triple_arbiter_pkg;

    localparam int NREQ  = 4;   // number of requesters
    localparam int ID_W  = 2;   // requester id width
    localparam int OP_W  = 3;   // operand width per requester
    localparam int CNT_W = 8;   // ones counter width

    // One-entry response buffer state
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    // 1 when at least two of the three operand bits are 1
    function automatic logic maj3(input logic [OP_W-1:0] op);
        return (op[0] & op[1]) | (op[0] & op[2]) | (op[1] & op[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pair_triple_arbiter_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Purpose  : Purely combinational 4-way round-robin arbiter. The search
//            starts at (last_grant+1) mod 4; the first requester found wins.
// Ports    : req        in   4  request vector
//            last_grant in   2  id of the most recent winner
//            enable     in   1  allow a grant this cycle
//            grant      out  4  one-hot grant (zero when disabled/no request)
//            grant_id   out  2  id of the selected requester
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4
    import pair_triple_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last_grant,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        idx      = '0;
        found    = 1'b0;
        grant_id = '0;
        // Offsets 1..NREQ; offset NREQ wraps back to last_grant itself, so
        // the previous winner is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            idx = last_grant + ID_W'(k);
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
        grant = (enable && found) ? (NREQ'(1) << grant_id) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/pair_triple_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pair_triple_arbiter
// Purpose  : Four requesters share one 2-of-3 majority detector. A
//            round-robin arbiter selects one operand per cycle; the result is
//            registered in a one-entry response buffer tagged with the id.
//            A wrapping 8-bit counter tracks accepted results equal to 1.
// Ports    : clk         in   1   clock
//            rst_n       in   1   asynchronous active-low reset
//            req_val     in   4   per-requester valid
//            req_rdy     out  4   one-hot ready (grant)
//            req_bits    in   12  operands, requester i at [3i+2:3i]
//            resp_val    out  1   buffer holds a result
//            resp_rdy    in   1   consumer accepts the result
//            resp_out    out  1   detector result
//            resp_id     out  2   id that produced resp_out
//            ones_count  out  8   count of accepted results equal to 1
// Revision : 1.0 - initial release
// ============================================================================
module pair_triple_arbiter
    import pair_triple_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_val,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ*OP_W-1:0] req_bits,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic                 resp_out,
    output logic [ID_W-1:0]      resp_id,
    output logic [CNT_W-1:0]     ones_count
);

    buf_state_t      state;
    buf_state_t      state_next;
    logic [ID_W-1:0] last_grant;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_id;
    logic            can_accept;
    logic            fire;
    logic [OP_W-1:0] operand;
    logic            det;

    // A full buffer can still accept when it drains on the same edge.
    // Gating with rst_n keeps every ready low while reset is held.
    assign can_accept = rst_n && ((state == ST_EMPTY) || resp_rdy);

    rr_arbiter4 u_arb (
        .req        (req_val),
        .last_grant (last_grant),
        .enable     (can_accept),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    assign req_rdy = grant;
    // grant is zero unless the winner is valid, so any set bit is a fire
    assign fire    = |grant;

    always_comb begin
        operand = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                operand = req_bits[i*OP_W +: OP_W];
            end
        end
    end

    assign det = maj3(operand);

    // Buffer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Buffer next-state
    always_comb begin
        state_next = state;
        if (fire) begin
            state_next = ST_FULL;
        end else if ((state == ST_FULL) && resp_rdy) begin
            state_next = ST_EMPTY;
        end
    end

    // Result payload, arbitration pointer and ones counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_out   <= 1'b0;
            resp_id    <= '0;
            last_grant <= ID_W'(NREQ - 1);
            ones_count <= '0;
        end else if (fire) begin
            resp_out   <= det;
            resp_id    <= grant_id;
            last_grant <= grant_id;
            if (det) begin
                ones_count <= ones_count + CNT_W'(1);
            end
        end
    end

    assign resp_val = (state == ST_FULL);

endmodule
`default_nettype wire

// File: tb/tb_pair_triple_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pair_triple_arbiter
// Purpose  : Self-checking bench for pair_triple_arbiter. Accepted operands
//            are pushed to a scoreboard queue with their expected result and
//            popped when the consumer takes the response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pair_triple_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_val;
    logic [3:0]  req_rdy;
    logic [11:0] req_bits;
    logic        resp_val;
    logic        resp_rdy;
    logic        resp_out;
    logic [1:0]  resp_id;
    logic [7:0]  ones_count;

    pair_triple_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_bits   (req_bits),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_out   (resp_out),
        .resp_id    (resp_id),
        .ones_count (ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic       res;
    } sb_t;

    typedef struct {
        logic [2:0] op;
        logic       exp;
    } tt_vec_t;

    sb_t        sbq[$];
    int         checks;
    int         errors;
    logic [7:0] exp_count;

    // Values sampled at the falling edge inside step()
    logic [3:0] s_req_rdy;
    logic       s_resp_val;
    logic       s_resp_out;
    logic [1:0] s_resp_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ref_maj(input logic [2:0] op);
        return ($countones(op) >= 2);
    endfunction

    // One clock cycle: sample at the falling edge, run the scoreboard,
    // then return 1 time unit after the next rising edge.
    task automatic step();
        sb_t e;
        @(negedge clk);
        s_req_rdy  = req_rdy;
        s_resp_val = resp_val;
        s_resp_out = resp_out;
        s_resp_id  = resp_id;
        if (rst_n) begin
            if (resp_val && resp_rdy) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_resp", 32'(resp_val), 32'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("sb_resp_id", 32'(resp_id), 32'(e.id));
                    chk("sb_resp_out", 32'(resp_out), 32'(e.res));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_val[i] && req_rdy[i]) begin
                    e.id  = 2'(i);
                    e.res = ref_maj(req_bits[i*3 +: 3]);
                    sbq.push_back(e);
                    if (e.res) exp_count = exp_count + 8'd1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_val  = 4'b0000;
        resp_rdy = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        sbq.delete();
        exp_count = 8'd0;
        rst_n     = 1'b1;
    endtask

    tt_vec_t    tt[8];
    logic [3:0] fair_exp[5];
    logic       held_out;
    logic [7:0] start_count;

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = 8'd0;
        req_bits  = 12'h000;

        tt[0] = '{3'b000, 1'b0};
        tt[1] = '{3'b001, 1'b0};
        tt[2] = '{3'b010, 1'b0};
        tt[3] = '{3'b100, 1'b0};
        tt[4] = '{3'b011, 1'b1};
        tt[5] = '{3'b101, 1'b1};
        tt[6] = '{3'b110, 1'b1};
        tt[7] = '{3'b111, 1'b1};
        fair_exp[0] = 4'b0001;
        fair_exp[1] = 4'b0010;
        fair_exp[2] = 4'b0100;
        fair_exp[3] = 4'b1000;
        fair_exp[4] = 4'b0001;

        // ---- reset state, with requests pending during reset
        req_val  = 4'b1111;
        resp_rdy = 1'b1;
        rst_n    = 1'b0;
        #3;
        chk("rst_req_rdy", 32'(req_rdy), 32'(0));
        chk("rst_resp_val", 32'(resp_val), 32'(0));
        chk("rst_resp_out", 32'(resp_out), 32'(0));
        chk("rst_resp_id", 32'(resp_id), 32'(0));
        chk("rst_ones_count", 32'(ones_count), 32'(0));
        do_reset();

        // ---- single request
        req_val  = 4'b0001;
        req_bits = 12'b000_000_000_011;
        resp_rdy = 1'b1;
        step();
        chk("single_req_rdy", 32'(s_req_rdy), 32'(4'b0001));
        chk("single_resp_val", 32'(resp_val), 32'(1));
        chk("single_resp_out", 32'(resp_out), 32'(1));
        chk("single_resp_id", 32'(resp_id), 32'(0));
        chk("single_ones_count", 32'(ones_count), 32'(1));
        req_val = 4'b0000;
        step();

        // ---- fairness with all requesters active
        do_reset();
        req_val  = 4'b1111;
        req_bits = 12'b111_110_001_000;
        resp_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("fair_grant", 32'(s_req_rdy), 32'(fair_exp[k]));
            chk("fair_resp_id", 32'(resp_id), 32'(k % 4));
        end
        req_val = 4'b0000;
        step();
        chk("fair_ones_count", 32'(ones_count), 32'(exp_count));

        // ---- backpressure
        do_reset();
        req_bits = 12'b001_110_000_000;
        req_val  = 4'b0100;
        resp_rdy = 1'b0;
        step();
        chk("bp_fill_grant", 32'(s_req_rdy), 32'(4'b0100));
        held_out = 1'b1;
        req_val  = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_req_rdy", 32'(s_req_rdy), 32'(0));
            chk("bp_resp_val", 32'(s_resp_val), 32'(1));
            chk("bp_resp_id", 32'(s_resp_id), 32'(2));
            chk("bp_resp_out", 32'(s_resp_out), 32'(held_out));
        end
        resp_rdy = 1'b1;
        step();
        chk("bp_release_grant", 32'(s_req_rdy), 32'(4'b1000));
        chk("bp_next_val", 32'(resp_val), 32'(1));
        chk("bp_next_id", 32'(resp_id), 32'(3));
        chk("bp_next_out", 32'(resp_out), 32'(0));
        req_val = 4'b0000;
        step();
        chk("bp_drained", 32'(resp_val), 32'(0));

        // ---- detector truth table across requesters
        do_reset();
        start_count = ones_count;
        resp_rdy    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_val  = 4'(1 << (k % 4));
            req_bits = 12'(tt[k].op) << (3 * (k % 4));
            step();
            chk("tt_resp_out", 32'(resp_out), 32'(tt[k].exp));
            chk("tt_resp_id", 32'(resp_id), 32'(k % 4));
        end
        req_val = 4'b0000;
        step();
        chk("tt_count_delta", 32'(8'(ones_count - start_count)), 32'(4));

        // ---- reset mid-operation
        req_val  = 4'b0100;
        req_bits = 12'hFFF;
        resp_rdy = 1'b0;
        step();
        chk("midrst_pre_val", 32'(resp_val), 32'(1));
        chk("midrst_pre_id", 32'(resp_id), 32'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_val", 32'(resp_val), 32'(0));
        chk("midrst_resp_out", 32'(resp_out), 32'(0));
        chk("midrst_resp_id", 32'(resp_id), 32'(0));
        chk("midrst_ones_count", 32'(ones_count), 32'(0));
        sbq.delete();
        exp_count = 8'd0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        req_val  = 4'b1111;
        resp_rdy = 1'b1;
        step();
        chk("midrst_first_grant", 32'(s_req_rdy), 32'(4'b0001));
        req_val = 4'b0000;
        step();

        // ---- ones counter wrap
        do_reset();
        req_val  = 4'b0001;
        req_bits = 12'b000_000_000_111;
        resp_rdy = 1'b1;
        for (int k = 0; k < 256; k++) begin
            step();
            if (k == 254) chk("wrap_255", 32'(ones_count), 32'(255));
            if (k == 255) chk("wrap_0", 32'(ones_count), 32'(0));
        end
        req_val = 4'b0000;
        step();
        chk("wrap_model", 32'(ones_count), 32'(exp_count));
        chk("sb_empty", 32'(sbq.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
